// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_BURST = 4;
  localparam int MAX_NREQ  = 8;
  localparam int MAX_BURST = 15;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
    return MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above the last owner, wrapping modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);

  localparam int OW = $clog2(NREQ);

  int          idx;
  logic [OW-1:0] sel;

  // Explicit wrap compare keeps non-power-of-2 NREQ from aliasing onto absent requesters.
  always_comb begin
    winner = last;
    valid  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = OW'(idx);
      if (!valid && req[sel]) begin
        valid  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers in bursts of up to BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int NREQ  = DEF_NREQ,
  parameter int BURST = DEF_BURST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic                    fifo_full,
  input  logic                    fifo_almost_full,
  output logic [NREQ-1:0]         gnt,
  output logic                    fifo_wr,
  output logic [DW-1:0]           fifo_din,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int         OW        = $clog2(NREQ);
  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("fifo_wr_arbiter: NREQ must be in 2..8");
  end
  if (BURST < 1 || BURST > MAX_BURST) begin : g_bad_burst
    $error("fifo_wr_arbiter: BURST must be in 1..15");
  end

  arb_state_t    state;
  logic [3:0]    beat;
  logic [DW-1:0] din_hold;
  logic [DW-1:0] cur_data;
  logic [OW-1:0] pick_idx;
  logic          pick_vld;
  logic          beat_ok;
  logic          end_burst;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .last   (owner),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  assign cur_data  = req_data[owner*DW +: DW];
  assign busy      = (state == ST_BURST);

  // FULL has priority over everything: a full FIFO stalls the beat even if ALMOST_FULL is also set.
  assign beat_ok   = busy && req[owner] && !fifo_full;
  assign end_burst = (beat == LAST_BEAT) || fifo_almost_full;

  assign gnt       = beat_ok ? NREQ'(onehot(3'(owner))) : '0;
  assign fifo_wr   = beat_ok;
  assign fifo_din  = beat_ok ? cur_data : din_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= OW'(NREQ - 1);
      beat     <= '0;
      din_hold <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner <= pick_idx;
            beat  <= '0;
            state <= ST_BURST;
          end
        end
        ST_BURST: begin
          // A dropped request ends the burst without a write; owner is kept so rotation continues.
          if (!req[owner]) begin
            state <= ST_IDLE;
          end else if (!fifo_full) begin
            din_hold <= cur_data;
            if (end_burst) begin
              beat  <= '0;
              state <= ST_IDLE;
            end else begin
              beat  <= beat + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
